// File: rtl/shifter_pkg.sv
// Shared definitions for the iterative shifter: mode encodings, FSM states
// and the pass-mode decode used by both the controller and the step datapath.
package shifter_pkg;

    localparam logic [2:0] MODE_PASS = 3'b000;
    localparam logic [2:0] MODE_SLL  = 3'b001;
    localparam logic [2:0] MODE_SRA  = 3'b010;
    localparam logic [2:0] MODE_SRL  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // 000, 110 and 111 all leave the operand untouched.
    function automatic logic is_pass(input logic [2:0] m);
        return !(m == MODE_SLL || m == MODE_SRL || m == MODE_SRA ||
                 m == MODE_ROL || m == MODE_ROR);
    endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift step of 0..STEP positions, returning the shifted
// accumulator and the last bit that left it (or wrapped round, for rotates).
module shift_step
    import shifter_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int STEP  = 4,
    localparam int AW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [2:0]       mode_q,
    input  logic [AW-1:0]    amount,
    output logic [WIDTH-1:0] acc_next,
    output logic             carry
);

    // One extra bit on the exit side captures the last bit shifted out.
    logic [WIDTH:0]   left_w;
    logic [WIDTH:0]   right_w;
    logic [WIDTH:0]   sra_w;
    logic [WIDTH-1:0] rol_w;
    logic [WIDTH-1:0] ror_w;

    assign left_w  = {1'b0, acc} << amount;
    assign right_w = {acc, 1'b0} >> amount;
    assign sra_w   = $signed({acc, 1'b0}) >>> amount;
    assign rol_w   = (acc << amount) | (acc >> (WIDTH - int'(amount)));
    assign ror_w   = (acc >> amount) | (acc << (WIDTH - int'(amount)));

    always_comb begin
        acc_next = acc;
        carry    = 1'b0;
        if (amount != '0) begin
            case (mode_q)
                MODE_SLL: begin acc_next = left_w[WIDTH-1:0]; carry = left_w[WIDTH];  end
                MODE_SRL: begin acc_next = right_w[WIDTH:1];  carry = right_w[0];     end
                MODE_SRA: begin acc_next = sra_w[WIDTH:1];    carry = sra_w[0];       end
                MODE_ROL: begin acc_next = rol_w;             carry = rol_w[0];       end
                MODE_ROR: begin acc_next = ror_w;             carry = ror_w[WIDTH-1]; end
                default:  begin acc_next = acc;               carry = 1'b0;           end
            endcase
        end
    end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle barrel shifter: shifts up to STEP positions per clock with a
// valid/ready request port and a held result port.
module iter_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               mode,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    input  logic [WIDTH-1:0]         data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out,
    output logic                     carry_out,
    output logic                     busy
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int AW = $clog2(STEP + 1);

    if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
        $error("iter_shifter: WIDTH must be in 2..64");
    end
    if (STEP < 1 || STEP > WIDTH) begin : g_bad_step
        $error("iter_shifter: STEP must be in 1..WIDTH");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [2:0]       mode_q, mode_d;
    logic             carry_q, carry_d;

    logic [CW-1:0]    cnt_ext;
    logic [CW-1:0]    step_w;
    logic [CW-1:0]    step_sel;
    logic [AW-1:0]    step_amt;
    logic [WIDTH-1:0] step_acc;
    logic             step_carry;
    logic             last_step;

    assign cnt_ext   = CW'(cnt_q);
    assign step_w    = CW'(STEP);
    assign last_step = (cnt_ext <= step_w);
    assign step_sel  = last_step ? cnt_ext : step_w;
    assign step_amt  = AW'(step_sel);

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .acc      (acc_q),
        .mode_q   (mode_q),
        .amount   (step_amt),
        .acc_next (step_acc),
        .carry    (step_carry)
    );

    // in_ready is gated by rst_n so it stays low for the whole reset pulse.
    assign in_ready  = rst_n && ((state_q == ST_IDLE) ||
                                 ((state_q == ST_DONE) && out_ready));
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_SHIFT);
    assign out       = acc_q;
    assign carry_out = carry_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        carry_d = carry_q;
        case (state_q)
            ST_SHIFT: begin
                acc_d   = step_acc;
                carry_d = step_carry;
                cnt_d   = SW'(cnt_ext - step_sel);
                if (last_step) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready && !in_valid) state_d = ST_IDLE;
            end
            default: ;
        endcase
        // Acceptance also covers DONE with out_ready, giving back-to-back issue.
        if (in_valid && in_ready) begin
            acc_d   = data;
            mode_d  = mode;
            cnt_d   = shamt;
            carry_d = 1'b0;
            state_d = (shamt == '0 || is_pass(mode)) ? ST_DONE : ST_SHIFT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            carry_q <= carry_d;
        end
    end

endmodule
